// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU front end: fetch FSM states,
// instruction width, PC step and reset PC, plus word-alignment helper.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  localparam int unsigned INSTR_W          = 32;
  localparam logic [31:0] PC_INCR          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry {word, pc} FIFO between fetch and decode. Entry 0 is always the
// head, so the head outputs come straight from registers.
module fetch_buffer
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               push,
  input  logic [INSTR_W-1:0] push_word,
  input  logic [31:0]        push_pc,
  input  logic               pop,
  output logic [INSTR_W-1:0] head_word,
  output logic [31:0]        head_pc,
  output logic               head_valid,
  output logic [1:0]         occupancy
);

  logic [INSTR_W-1:0] word0_r, word1_r;
  logic [31:0]        pc0_r, pc1_r;
  logic [1:0]         occ_r;
  logic               do_push_s, do_pop_s;

  // Qualify push/pop against current fill level
  always_comb begin
    do_pop_s  = pop && (occ_r != 2'd0);
    do_push_s = push && ((occ_r != 2'd2) || do_pop_s);
  end

  // Entry storage and occupancy; flush discards everything including a push
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word0_r <= '0;
      word1_r <= '0;
      pc0_r   <= 32'd0;
      pc1_r   <= 32'd0;
      occ_r   <= 2'd0;
    end else if (flush) begin
      word0_r <= '0;
      word1_r <= '0;
      pc0_r   <= 32'd0;
      pc1_r   <= 32'd0;
      occ_r   <= 2'd0;
    end else begin
      case ({do_push_s, do_pop_s})
        2'b10: begin
          if (occ_r == 2'd0) begin
            word0_r <= push_word;
            pc0_r   <= push_pc;
          end else begin
            word1_r <= push_word;
            pc1_r   <= push_pc;
          end
          occ_r <= occ_r + 2'd1;
        end
        2'b01: begin
          word0_r <= word1_r;
          pc0_r   <= pc1_r;
          occ_r   <= occ_r - 2'd1;
        end
        2'b11: begin
          if (occ_r == 2'd1) begin
            word0_r <= push_word;
            pc0_r   <= push_pc;
          end else begin
            word0_r <= word1_r;
            pc0_r   <= pc1_r;
            word1_r <= push_word;
            pc1_r   <= push_pc;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign head_word  = word0_r;
  assign head_pc    = pc0_r;
  assign head_valid = (occ_r != 2'd0);
  assign occupancy  = occ_r;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, imem request/ack FSM, redirect/flush handling.
// Optional decode-starve counter enabled by `define FETCH_STALL_CNT_EN.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic               CLK,
  input  logic               RESET,
  output logic               IMEM_REQ,
  output logic [31:0]        IMEM_ADDR,
  input  logic               IMEM_ACK,
  input  logic [INSTR_W-1:0] IMEM_RDATA,
  output logic [INSTR_W-1:0] INSTRUCTION,
  output logic [31:0]        INSTR_PC,
  output logic               INSTR_VALID,
  input  logic               INSTR_READY,
`ifdef FETCH_STALL_CNT_EN
  output logic [15:0]        STALL_CNT,
`endif
  input  logic               REDIRECT_VALID,
  input  logic [31:0]        REDIRECT_PC
);

  fetch_state_e state_r, state_next_s;
  logic         req_r, req_next_s;
  logic [31:0]  addr_r, addr_next_s;
  logic [31:0]  pc_r, pc_next_s;
  logic         push_s, pop_s, issue_ok_s;
  logic [1:0]   occ_s, occ_post_s;
  logic         head_valid_s;

  fetch_buffer u_fetch_buffer (
    .clk        (CLK),
    .rst_n      (RESET),
    .flush      (REDIRECT_VALID),
    .push       (push_s),
    .push_word  (IMEM_RDATA),
    .push_pc    (addr_r),
    .pop        (pop_s),
    .head_word  (INSTRUCTION),
    .head_pc    (INSTR_PC),
    .head_valid (head_valid_s),
    .occupancy  (occ_s)
  );

  // Post-edge occupancy decides whether another request may be in flight
  always_comb begin
    push_s     = (state_r == REQ) && IMEM_ACK;
    pop_s      = head_valid_s && INSTR_READY;
    occ_post_s = occ_s + {1'b0, push_s} - {1'b0, pop_s};
    issue_ok_s = !occ_post_s[1];
  end

  // Next state, request and PC; redirect overrides everything
  always_comb begin
    state_next_s = state_r;
    req_next_s   = req_r;
    addr_next_s  = addr_r;
    pc_next_s    = pc_r;
    if (REDIRECT_VALID) begin
      pc_next_s  = align_pc(REDIRECT_PC);
      req_next_s = 1'b1;
      if ((state_r == IDLE) || IMEM_ACK) begin
        state_next_s = REQ;
        addr_next_s  = align_pc(REDIRECT_PC);
      end else begin
        state_next_s = DROP;
      end
    end else begin
      case (state_r)
        IDLE: begin
          if (issue_ok_s) begin
            state_next_s = REQ;
            req_next_s   = 1'b1;
            addr_next_s  = pc_r;
          end else begin
            req_next_s = 1'b0;
          end
        end
        REQ: begin
          if (IMEM_ACK) begin
            pc_next_s = pc_r + PC_INCR;
            if (issue_ok_s) begin
              addr_next_s = pc_r + PC_INCR;
            end else begin
              state_next_s = IDLE;
              req_next_s   = 1'b0;
            end
          end else begin
            state_next_s = REQ;
          end
        end
        DROP: begin
          // stale data discarded; the redirected fetch goes out now
          if (IMEM_ACK) begin
            state_next_s = REQ;
            addr_next_s  = pc_r;
          end else begin
            state_next_s = DROP;
          end
        end
        default: begin
          state_next_s = IDLE;
          req_next_s   = 1'b0;
        end
      endcase
    end
  end

  // FSM and request registers
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_r <= IDLE;
      req_r   <= 1'b0;
      addr_r  <= 32'd0;
      pc_r    <= align_pc(RESET_PC);
    end else begin
      state_r <= state_next_s;
      req_r   <= req_next_s;
      addr_r  <= addr_next_s;
      pc_r    <= pc_next_s;
    end
  end

  assign IMEM_REQ    = req_r;
  assign IMEM_ADDR   = addr_r;
  assign INSTR_VALID = head_valid_s;

`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_cnt_r;

  // Saturating count of edges where decode has nothing to consume
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      stall_cnt_r <= 16'd0;
    end else if (!head_valid_s && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign STALL_CNT = stall_cnt_r;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit (optionally with
// FETCH_STALL_CNT_EN defined to cover the stall counter).
module tb_instr_fetch_unit;

  logic        CLK;
  logic        RESET;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_ACK;
  logic [31:0] IMEM_RDATA;
  logic [31:0] INSTRUCTION;
  logic [31:0] INSTR_PC;
  logic        INSTR_VALID;
  logic        INSTR_READY;
  logic        REDIRECT_VALID;
  logic [31:0] REDIRECT_PC;
`ifdef FETCH_STALL_CNT_EN
  logic [15:0] STALL_CNT;
`endif

  int n_checks = 0;
  int n_errors = 0;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .IMEM_REQ       (IMEM_REQ),
    .IMEM_ADDR      (IMEM_ADDR),
    .IMEM_ACK       (IMEM_ACK),
    .IMEM_RDATA     (IMEM_RDATA),
    .INSTRUCTION    (INSTRUCTION),
    .INSTR_PC       (INSTR_PC),
    .INSTR_VALID    (INSTR_VALID),
    .INSTR_READY    (INSTR_READY),
`ifdef FETCH_STALL_CNT_EN
    .STALL_CNT      (STALL_CNT),
`endif
    .REDIRECT_VALID (REDIRECT_VALID),
    .REDIRECT_PC    (REDIRECT_PC)
  );

  function automatic logic [31:0] word_of(input logic [31:0] addr);
    return addr ^ 32'hC0DE_0000;
  endfunction

  // memory returns an address-derived word
  assign IMEM_RDATA = word_of(IMEM_ADDR);

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset(input logic ack, input logic ready);
    RESET          = 1'b0;
    IMEM_ACK       = ack;
    INSTR_READY    = ready;
    REDIRECT_VALID = 1'b0;
    REDIRECT_PC    = 32'd0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
  endtask

  initial begin
    RESET          = 1'b0;
    IMEM_ACK       = 1'b0;
    INSTR_READY    = 1'b0;
    REDIRECT_VALID = 1'b0;
    REDIRECT_PC    = 32'd0;
    #12;
    check("rst_req",   {31'd0, IMEM_REQ},    32'd0);
    check("rst_addr",  IMEM_ADDR,            32'd0);
    check("rst_valid", {31'd0, INSTR_VALID}, 32'd0);
    check("rst_instr", INSTRUCTION,          32'd0);
    check("rst_pc",    INSTR_PC,             32'd0);
`ifdef FETCH_STALL_CNT_EN
    check("rst_stall", {16'd0, STALL_CNT},   32'd0);
`endif

    // streaming: one instruction per cycle
    do_reset(1'b1, 1'b1);
    step();
    check("s_req1",   {31'd0, IMEM_REQ},    32'd1);
    check("s_addr1",  IMEM_ADDR,            32'd0);
    check("s_valid1", {31'd0, INSTR_VALID}, 32'd0);
    step();
    check("s_valid2", {31'd0, INSTR_VALID}, 32'd1);
    check("s_pc2",    INSTR_PC,             32'd0);
    check("s_word2",  INSTRUCTION,          word_of(32'd0));
    check("s_addr2",  IMEM_ADDR,            32'd4);
    for (int k = 1; k <= 4; k++) begin
      step();
      check("s_pc_seq",   INSTR_PC,    32'(4 * k));
      check("s_word_seq", INSTRUCTION, word_of(32'(4 * k)));
    end

    // backpressure: queue fills, request drops, head stable
    do_reset(1'b1, 1'b0);
    repeat (5) step();
    check("bp_req",   {31'd0, IMEM_REQ},    32'd0);
    check("bp_valid", {31'd0, INSTR_VALID}, 32'd1);
    check("bp_head",  INSTR_PC,             32'd0);
    INSTR_READY = 1'b1;
    step();
    check("bp_pc4",   INSTR_PC,          32'd4);
    check("bp_req2",  {31'd0, IMEM_REQ}, 32'd1);
    check("bp_addr8", IMEM_ADDR,         32'd8);
    step();
    check("bp_pc8",   INSTR_PC,          32'd8);

    // redirect while request pending, stale ACK later
    do_reset(1'b0, 1'b1);
    step();
    REDIRECT_VALID = 1'b1;
    REDIRECT_PC    = 32'h0000_0040;
    step();
    REDIRECT_VALID = 1'b0;
    check("rd_req",   {31'd0, IMEM_REQ},    32'd1);
    check("rd_addr",  IMEM_ADDR,            32'd0);
    check("rd_valid", {31'd0, INSTR_VALID}, 32'd0);
    repeat (2) step();
    IMEM_ACK = 1'b1;
    step();
    check("rd_drop_valid", {31'd0, INSTR_VALID}, 32'd0);
    check("rd_new_addr",   IMEM_ADDR,            32'h0000_0040);
    step();
    check("rd_valid2", {31'd0, INSTR_VALID}, 32'd1);
    check("rd_pc40",   INSTR_PC,             32'h0000_0040);
    check("rd_word40", INSTRUCTION,          word_of(32'h0000_0040));

    // redirect coincident with ACK and pop, unaligned target
    REDIRECT_VALID = 1'b1;
    REDIRECT_PC    = 32'h0000_0103;
    step();
    REDIRECT_VALID = 1'b0;
    check("rc_valid", {31'd0, INSTR_VALID}, 32'd0);
    check("rc_addr",  IMEM_ADDR,            32'h0000_0100);
    step();
    check("rc_pc",    INSTR_PC,             32'h0000_0100);
    check("rc_word",  INSTRUCTION,          word_of(32'h0000_0100));

    // PC wrap at top of address space
    REDIRECT_VALID = 1'b1;
    REDIRECT_PC    = 32'hFFFF_FFFC;
    step();
    REDIRECT_VALID = 1'b0;
    check("wr_addr_top", IMEM_ADDR, 32'hFFFF_FFFC);
    step();
    check("wr_addr_zero", IMEM_ADDR, 32'd0);
    check("wr_pc_top",    INSTR_PC,  32'hFFFF_FFFC);
    step();
    check("wr_pc_zero",   INSTR_PC,  32'd0);

    // asynchronous reset mid-request clears outputs at once
    RESET = 1'b0;
    #1;
    check("ar_req",   {31'd0, IMEM_REQ},    32'd0);
    check("ar_addr",  IMEM_ADDR,            32'd0);
    check("ar_valid", {31'd0, INSTR_VALID}, 32'd0);
    check("ar_instr", INSTRUCTION,          32'd0);
    check("ar_pc",    INSTR_PC,             32'd0);
`ifdef FETCH_STALL_CNT_EN
    check("ar_stall", {16'd0, STALL_CNT},   32'd0);
`endif
    @(negedge CLK);
    RESET = 1'b1;
    step();
    check("ar_late_ack", {31'd0, INSTR_VALID}, 32'd0);
    check("ar_req1",     {31'd0, IMEM_REQ},    32'd1);

    // starved decode for 10 edges
    do_reset(1'b0, 1'b1);
    repeat (10) step();
    check("st_valid", {31'd0, INSTR_VALID}, 32'd0);
`ifdef FETCH_STALL_CNT_EN
    check("st_cnt",   {16'd0, STALL_CNT},   32'd10);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage of the 8-bit CPU: owns the program counter, reads 32-bit instruction words from instruction memory over a request/acknowledge handshake, and buffers them in a 2-entry queue. It feeds `INSTRUCTION` directly into `control_unit` (decode) using a valid/ready handshake. It accepts PC redirects (jump/branch) computed downstream and flushes stale words.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; low 2 bits must be 0.
- `CLK` in 1: single clock; all state updates on rising edge.
- `RESET` in 1: reset, asynchronous, active-low.
- `IMEM_REQ` out 1: read request to instruction memory; registered.
- `IMEM_ADDR` out 32: byte address of the requested word; registered; bits [1:0] always 0.
- `IMEM_ACK` in 1: memory accepts and completes the request this cycle; sampled at rising edge.
- `IMEM_RDATA` in 32: instruction word; valid when `IMEM_ACK`=1.
- `INSTRUCTION` out 32: head-of-queue instruction to `control_unit`.
- `INSTR_PC` out 32: byte address of `INSTRUCTION`.
- `INSTR_VALID` out 1: `INSTRUCTION`/`INSTR_PC` are valid.
- `INSTR_READY` in 1: decode consumes head when `INSTR_VALID`&`INSTR_READY` at an edge.
- `REDIRECT_VALID` in 1: redirect fetch to `REDIRECT_PC`.
- `REDIRECT_PC` in 32: new fetch byte address; bits [1:0] ignored (forced 0).
- `STALL_CNT` out 16: decode-starve counter (only with `FETCH_STALL_CNT_EN`).

## Operation
- Reset (`RESET`=0): PC=`RESET_PC`, queue empty, state IDLE; `IMEM_REQ`=0, `IMEM_ADDR`=0, `INSTR_VALID`=0, `INSTRUCTION`=0, `INSTR_PC`=0, `STALL_CNT`=0. Reset mid-request abandons it; a late `IMEM_ACK` after reset release is ignored unless `IMEM_REQ`=1.
- States: IDLE (no request outstanding), REQ (`IMEM_REQ`=1, waiting for ACK), DROP (`IMEM_REQ`=1, outstanding request belongs to a flushed path; its data is discarded).
- Issue rule: request (re)issued at an edge when post-edge occupancy ≤ 1 and no redirect-drop pending; `IMEM_ADDR`=PC, PC+=4 on acceptance (ACK edge). Occupancy counts buffered words only; at most one request outstanding.
- IDLE→REQ when issue rule holds. REQ→REQ on ACK with issue rule still true (back-to-back, new address = old+4). REQ→IDLE on ACK when queue would be full. REQ→DROP on redirect without ACK at the same edge. DROP→REQ (address = redirected PC) on ACK; ACK data dropped.
- Redirect (highest priority): at the edge, queue flushed (including a word being pushed), any pop that edge is void, PC=`REDIRECT_PC`&~3. If no request outstanding, or ACK arrives at that same edge: next state REQ with `IMEM_ADDR`=new PC.
- Queue: 2 entries {word, pc}; simultaneous push and pop allowed when full (occupancy unchanged). Push only on ACK in REQ. PC arithmetic wraps modulo 2^32 (32'hFFFF_FFFC+4 → 0).

## Timing
- First `IMEM_REQ`=1 at first rising edge after `RESET` deasserts, `IMEM_ADDR`=`RESET_PC`.
- ACK edge → `INSTR_VALID`=1 with that word after the same edge (1-cycle fetch-to-decode latency when queue empty).
- With `IMEM_ACK` tied 1 and `INSTR_READY`=1: one instruction per cycle, sequential PCs.
- Redirect edge → `INSTR_VALID`=0 after it; first redirected word valid one edge after its ACK (DROP adds the wait for the stale ACK).
- `INSTR_VALID` held and head stable while `INSTR_READY`=0.

## Configuration
- `FETCH_STALL_CNT_EN` defined: `STALL_CNT` port exists; increments each edge with `RESET`=1 and `INSTR_VALID`=0; saturates at 16'hFFFF; cleared only by reset.
- Not defined: port and counter absent; all other behaviour identical.

## Structure
- Shared package `cpu_pkg`: fetch state typedef (IDLE/REQ/DROP), `PC_INCR`=4, `INSTR_W`=32, default reset PC constant.
- One sub-module: `fetch_buffer` (2-entry {word, pc} FIFO with flush, push, pop, occupancy).

## Test plan
- Reset release, `IMEM_ACK`=1, RDATA=addr-derived, `INSTR_READY`=1 → `INSTR_PC`=0,4,8,… one per cycle, first valid 2 edges after reset release.
- `INSTR_READY`=0 for 5 cycles → queue fills to 2, `IMEM_REQ` drops, head stays PC 0; release → PCs 0,4,8 in order, no loss/duplicate.
- Redirect to 32'h40 while REQ pending, ACK 3 cycles later → stale word discarded, next `IMEM_ADDR`=32'h40, `INSTR_PC`=32'h40 delivered.
- Redirect to 32'h103 coincident with ACK and pop → queue empty, `IMEM_ADDR`=32'h100 next cycle, no stale word visible.
- PC at 32'hFFFF_FFFC, ACK → next `IMEM_ADDR`=0.
- `FETCH_STALL_CNT_EN`, `IMEM_ACK`=0 for 10 cycles after reset → `STALL_CNT`=10; `RESET` pulsed low mid-request → all outputs 0 immediately, `STALL_CNT`=0.
